// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the BCD conversion arbiter.
// Holds the FSM state enum, BCD constants and the add-3 digit fix.
package bcd_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int BCD_DIGITS = 4;
   localparam int BCD_MAX    = 9999;

   // Double-dabble pre-shift correction for one digit
   function automatic logic [3:0] add3_fix(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bundle of the BCD conversion arbiter.
// req/req_bin in; gnt/done/bcd_out/ovf/busy back to the requesters.
interface bcd_conv_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int BIN_W = 14
);

   logic [NREQ-1:0]       req;
   logic [NREQ*BIN_W-1:0] req_bin;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic [15:0]           bcd_out;
   logic                  ovf;
   logic                  busy;

   modport master (
      output req, req_bin,
      input  gnt, done, bcd_out, ovf, busy
   );

   modport slave (
      input  req, req_bin,
      output gnt, done, bcd_out, ovf, busy
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to 4-digit BCD converter.
// Ports: start_i/bin_i load an operand; busy_o, done_o, bcd_o report.
module bin2bcd_seq
   import bcd_ctrl_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [BIN_W-1:0] bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [15:0]      bcd_o
);

   localparam int DW = 4 * BCD_DIGITS;
   localparam int SW = DW + BIN_W;
   localparam int CW = $clog2(BIN_W + 1);

   logic [SW-1:0] sc_q, sc_d, fix;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;
   logic          last;

   assign last = (cnt_q == CW'(BIN_W - 1));

   always_comb begin
      fix = sc_q;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         fix[BIN_W+4*d +: 4] = add3_fix(sc_q[BIN_W+4*d +: 4]);
      end
   end

   // Top bit falls off the thousands digit: result is bin mod 10000
   always_comb begin
      sc_d  = sc_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (start_i) begin
         sc_d  = {{DW{1'b0}}, bin_i};
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         sc_d  = {fix[SW-2:0], 1'b0};
         cnt_d = cnt_q + 1'b1;
         if (last) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sc_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         sc_q  <= sc_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign busy_o = run_q;
   assign done_o = run_q & last;
   assign bcd_o  = sc_q[SW-1 -: DW];

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bin2bcd_seq among NREQ requesters.
// Ports: clk, rst (sync, active-high), bus (slave). Option: BCD_SAT_EN.
module bcd_conv_arbiter
   import bcd_ctrl_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int BIN_W = 14
) (
   input  logic               clk,
   input  logic               rst,
   bcd_conv_arbiter_if.slave  bus
);

   localparam int PW = $clog2(NREQ);

   state_t           state_q, state_d;
   logic [PW-1:0]    rr_q, rr_d;
   logic [PW-1:0]    win_q, win_d;
   logic [BIN_W-1:0] opnd_q, opnd_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic [15:0]      bcd_q, bcd_d;
   logic             ovf_q, ovf_d;

   logic             found;
   logic [PW-1:0]    sel;
   int               scan;
   logic [BIN_W-1:0] sel_bin;
   logic             start;
   logic             cv_busy, cv_done;
   logic [15:0]      cv_bcd;
   logic             ovf_c;

   // First set req at or above rr_q, wrapping
   always_comb begin
      found = 1'b0;
      sel   = '0;
      scan  = 0;
      for (int i = 0; i < NREQ; i++) begin
         scan = int'(rr_q) + i;
         if (scan >= NREQ) scan = scan - NREQ;
         if (!found && bus.req[scan]) begin
            found = 1'b1;
            sel   = PW'(scan);
         end
      end
   end

   assign sel_bin = bus.req_bin[int'(sel)*BIN_W +: BIN_W];
   assign ovf_c   = (32'(opnd_q) > 32'(BCD_MAX));

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      win_d   = win_q;
      opnd_d  = opnd_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      start   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               win_d   = sel;
               opnd_d  = sel_bin;
               gnt_d   = NREQ'(1) << sel;
               start   = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (cv_done || !cv_busy) state_d = DONE;
         end
         DONE: begin
`ifdef BCD_SAT_EN
            bcd_d = ovf_c ? 16'h9999 : cv_bcd;
`else
            bcd_d = cv_bcd;
`endif
            ovf_d   = ovf_c;
            done_d  = NREQ'(1) << win_q;
            gnt_d   = '0;
            rr_d    = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         win_q   <= '0;
         opnd_q  <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
         opnd_q  <= opnd_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .bin_i   (sel_bin),
      .busy_o  (cv_busy),
      .done_o  (cv_done),
      .bcd_o   (cv_bcd)
   );

   assign bus.gnt     = gnt_q;
   assign bus.done    = done_q;
   assign bus.bcd_out = bcd_q;
   assign bus.ovf     = ovf_q;
   assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed scenarios plus random traffic
// checked every cycle against a timeline/arithmetic reference model.
module tb_bcd_conv_arbiter;

   localparam int NREQ  = 4;
   localparam int BIN_W = 14;
   localparam int LAT   = BIN_W + 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_conv_arbiter_if #(.NREQ(NREQ), .BIN_W(BIN_W)) bus ();

   bcd_conv_arbiter #(.NREQ(NREQ), .BIN_W(BIN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: cycles since grant, plus plain decimal arithmetic
   int              m_cnt = 0;
   int              m_rr  = 0;
   int              m_win = 0;
   int              m_bin = 0;
   logic [NREQ-1:0] e_gnt  = '0;
   logic [NREQ-1:0] e_done = '0;
   logic [15:0]     e_bcd  = '0;
   logic            e_ovf  = 1'b0;
   logic            e_busy = 1'b0;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      v = v % 10000;
      r[15:12] = 4'(v / 1000);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cnt = 0; m_rr = 0; m_win = 0;
         e_gnt = '0; e_done = '0; e_bcd = '0;
         e_ovf = 1'b0; e_busy = 1'b0;
      end else begin
         e_done = '0;
         if (m_cnt == 0) begin
            for (int k = 0; k < NREQ; k++) begin
               if (m_cnt == 0 && bus.req[(m_rr + k) % NREQ]) begin
                  m_win = (m_rr + k) % NREQ;
                  m_bin = int'(bus.req_bin[m_win*BIN_W +: BIN_W]);
                  e_gnt = '0;
                  e_gnt[m_win] = 1'b1;
                  e_busy = 1'b1;
                  m_cnt = 1;
               end
            end
         end else if (m_cnt <= BIN_W) begin
            m_cnt++;
         end else begin
            e_done[m_win] = 1'b1;
            e_ovf = (m_bin > 9999);
`ifdef BCD_SAT_EN
            e_bcd = e_ovf ? 16'h9999 : to_bcd(m_bin);
`else
            e_bcd = to_bcd(m_bin);
`endif
            e_gnt = '0;
            e_busy = 1'b0;
            m_rr = (m_win + 1) % NREQ;
            m_cnt = 0;
         end
      end
   end

   bit hold = 0;
   bit rand_en = 0;

   function automatic int pick();
      case ($urandom_range(0, 3))
         0: return int'($urandom_range(0, 9999));
         1: return int'($urandom_range(0, 16383));
         2: return 9999;
         default: return 10000;
      endcase
   endfunction

   task automatic set_req(input int i, input int v);
      bus.req[i] = 1'b1;
      bus.req_bin[i*BIN_W +: BIN_W] = BIN_W'(v);
   endtask

   task automatic tick();
      @(negedge clk);
      chk("gnt",  32'(bus.gnt),     32'(e_gnt));
      chk("done", 32'(bus.done),    32'(e_done));
      chk("busy", 32'(bus.busy),    32'(e_busy));
      chk("bcd",  32'(bus.bcd_out), 32'(e_bcd));
      chk("ovf",  32'(bus.ovf),     32'(e_ovf));
      for (int i = 0; i < NREQ; i++) begin
         if (e_done[i] && !hold) begin
            bus.req[i] = 1'b0;
         end else if (rand_en && !bus.req[i]
                      && $urandom_range(0, 7) == 0) begin
            set_req(i, pick());
         end else if (rand_en && e_gnt[i]
                      && $urandom_range(0, 3) == 0) begin
            bus.req_bin[i*BIN_W +: BIN_W] = BIN_W'($urandom);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_done(input int i, output int gl);
      bit seen = 0;
      gl = 0;
      for (int c = 0; c < NREQ * LAT + 8 && !seen; c++) begin
         tick();
         if (bus.gnt[i]) gl++;
         if (bus.done[i]) seen = 1;
      end
      if (!seen) chk("wait_done", 32'(bus.done), 32'(1 << i));
   endtask

   int gl;
   int k;
   int idx;
   int ord[5] = '{0, 1, 2, 3, 0};
   logic [15:0] fb[5] = '{16'h0001, 16'h0022, 16'h0333, 16'h4444, 16'h0001};

   initial begin
      rst = 1'b1;
      bus.req = '0;
      bus.req_bin = '0;
      @(negedge clk);
      tick();
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_bcd", 32'(bus.bcd_out), 32'h0);
      rst = 1'b0;

      // single request
      set_req(0, 1234);
      wait_done(0, gl);
      chk("single_gntlen", 32'(gl), 32'(BIN_W + 1));
      chk("single_bcd", 32'(bus.bcd_out), 32'h1234);
      chk("single_ovf", 32'(bus.ovf), 32'h0);

      // fairness with all requesters held
      do_reset();
      hold = 1;
      set_req(0, 1); set_req(1, 22); set_req(2, 333); set_req(3, 4444);
      k = 0;
      for (int c = 0; c < 6 * LAT && k < 5; c++) begin
         tick();
         if (bus.done != '0) begin
            idx = -1;
            for (int j = 0; j < NREQ; j++) if (bus.done[j]) idx = j;
            chk("fair_who", 32'(idx), 32'(ord[k]));
            chk("fair_bcd", 32'(bus.bcd_out), 32'(fb[k]));
            k++;
         end
      end
      chk("fair_cnt", 32'(k), 32'd5);
      hold = 0;
      bus.req = '0;
      repeat (LAT) tick();

      // late arrival during RUN
      set_req(0, 100);
      repeat (5) tick();
      set_req(2, 250);
      wait_done(0, gl);
      tick();
      chk("late_gnt", 32'(bus.gnt), 32'h4);
      wait_done(2, gl);
      chk("late_bcd", 32'(bus.bcd_out), 32'h0250);

      // overflow
      set_req(1, 16383);
      wait_done(1, gl);
`ifdef BCD_SAT_EN
      chk("ovf_bcd", 32'(bus.bcd_out), 32'h9999);
`else
      chk("ovf_bcd", 32'(bus.bcd_out), 32'h6383);
`endif
      chk("ovf_flag", 32'(bus.ovf), 32'h1);

      // reset mid-operation
      set_req(0, 5000);
      for (int c = 0; c < LAT && !bus.gnt[0]; c++) tick();
      repeat (7) tick();
      do_reset();
      chk("rstmid_gnt", 32'(bus.gnt), 32'h0);
      chk("rstmid_bcd", 32'(bus.bcd_out), 32'h0);
      set_req(1, 9999);
      wait_done(1, gl);
      chk("max_bcd", 32'(bus.bcd_out), 32'h9999);
      chk("max_ovf", 32'(bus.ovf), 32'h0);

      // operand change after grant
      set_req(3, 42);
      for (int c = 0; c < LAT && !bus.gnt[3]; c++) tick();
      tick();
      bus.req_bin[3*BIN_W +: BIN_W] = BIN_W'(77);
      wait_done(3, gl);
      chk("hold_opnd", 32'(bus.bcd_out), 32'h0042);

      // random traffic
      rand_en = 1;
      repeat (2000) tick();
      rand_en = 0;
      bus.req = '0;
      repeat (LAT + 2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
